ascon_perm_ctrl: RTL and testbench
==================================

// Module: ascon_perm_ctrl
// PURPOSE
//  Sequences the Ascon permutation datapath: accepts a permutation request (op mode), drives per-round
//  enable + round-constant index for pa (12) or pb (6/8) rounds, and signals completion. Arbitrates
//  state-register access between the SPI subnode (host loads/reads) and the running permutation.
//  Sits between spi_subnode and asconp inside the top-level wrapper.
// PARAMETERS
//  NUM_ROUNDS_A  12  rounds for init/final permutation (pa); legal 1..12
//  NUM_ROUNDS_B  6   rounds for AD/PT permutation (pb); 6 = Ascon-128, 8 = Ascon-128a; legal 1..12
// PORTS
//  clk           in   1  system clock, all logic on rising edge
//  rst           in   1  synchronous, active-high reset
//  req_valid     in   1  permutation request valid
//  req_ready     out  1  request accepted when req_valid && req_ready
//  req_mode      in   3  op mode (ascon_pkg::OP_*), sampled on accept
//  host_wr_req   in   1  SPI subnode wants to write state registers
//  host_wr_gnt   out  1  state write permitted this cycle
//  round_en      out  1  asconp applies one round this cycle
//  round_idx     out  4  round-constant index (0..11) for the current round
//  busy          out  1  permutation in progress (LOAD or ROUND)
//  done          out  1  one-cycle pulse after last round
//  err_mode      out  1  sticky: illegal mode offered; cleared by rst only
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=0 for the reset cycle then per rule below; host_wr_gnt, round_en, busy,
//   done, err_mode=0; round_idx=0. Reset mid-permutation aborts at once; asconp state left as-is.
//  Modes (ascon_pkg): OP_NOP=0, OP_INIT=1 (pa), OP_AD=2 (pb), OP_PT=3 (pb), OP_FINAL=4 (pa), 5-7 illegal.
//  FSM IDLE -> LOAD -> ROUND -> DONE -> IDLE.
//   IDLE : req_ready = !host_wr_req (host write has priority; request held, not lost).
//          Accept of OP_INIT/AD/PT/FINAL -> LOAD; latch n = pa or pb. OP_NOP accept -> stay IDLE, no done.
//          Illegal mode: accepted (ready high), err_mode set, stay IDLE, no done.
//   LOAD : busy=1, round_en=0; counter r=0 -> ROUND.
//   ROUND: busy=1, round_en=1, round_idx = 12 - n + r; r++ each cycle; after r = n-1 -> DONE.
//   DONE : done=1 for exactly one cycle, busy=0, req_ready=0 -> IDLE.
//  Latency: accept at edge t -> round_en high cycles t+2..t+1+n -> done at cycle t+2+n
//   (pa=12: done 14 cycles after accept; pb=6: 8 cycles). Back-to-back: next accept earliest in cycle after DONE.
//  host_wr_gnt = host_wr_req && state==IDLE (combinational on state); always 0 in LOAD/ROUND/DONE.
//  Simultaneous host_wr_req and req_valid in IDLE: grant host, req_ready=0.
//  req_mode/req_valid changes while busy are ignored; round_idx holds last value outside ROUND.
//  Counter width 4 bits; n in 1..12 so no wrap; params outside 1..12 are a compile-time $error.
// CONFIGURATION
//  ASCON_PERF_CNT_EN defined: adds outputs perm_cnt[15:0] (count of completed permutations, +1 on done,
//   wraps 0xFFFF->0) and round_cnt[23:0] (total round_en cycles, wraps); both reset to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  ascon_pkg: OP_* mode localparams, state encoding (IDLE/LOAD/ROUND/DONE), RC_IDX_W=4, MAX_ROUNDS=12.
//  One sub-module: ascon_round_cnt (load n, step, emits round_idx and last flag); FSM, arbitration
//  and optional perf counters stay in ascon_perm_ctrl.
// TESTING
//  1. Reset, then OP_INIT accepted at cycle 0 -> round_en cycles 2..13, round_idx 0..11, done at 14 only.
//  2. OP_AD with NUM_ROUNDS_B=6 -> round_idx 6..11 over 6 cycles, done 8 cycles after accept;
//     repeat with NUM_ROUNDS_B=8 -> idx 4..11, done at 10.
//  3. host_wr_req and req_valid(OP_PT) same IDLE cycle -> host_wr_gnt=1, req_ready=0; drop host_wr_req
//     -> request accepted next cycle; host_wr_req during ROUND -> gnt=0 until after DONE.
//  4. req_mode=6 -> err_mode=1 sticky, no busy, no done; following OP_FINAL runs normally, err_mode stays 1.
//  5. rst asserted at round 5 of OP_INIT -> next cycle IDLE, busy/round_en/done=0, no done pulse later.
//  6. ASCON_PERF_CNT_EN: three permutations (INIT, AD, FINAL with pb=6) -> perm_cnt=3, round_cnt=30.

Source files
------------

// File: rtl/ascon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ascon_pkg
//  Description : Shared definitions for the Ascon permutation controller:
//                operation-mode codes, FSM state encoding, round-counter
//                width and the maximum round count, plus mode helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package ascon_pkg;

    localparam int RC_IDX_W   = 4;
    localparam int MAX_ROUNDS = 12;

    // Operation modes offered with a permutation request
    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_INIT  = 3'd1;
    localparam logic [2:0] OP_AD    = 3'd2;
    localparam logic [2:0] OP_PT    = 3'd3;
    localparam logic [2:0] OP_FINAL = 3'd4;

    // Controller state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // True for the four modes that actually run the permutation
    function automatic logic op_is_perm(input logic [2:0] mode);
        return (mode >= OP_INIT) && (mode <= OP_FINAL);
    endfunction

    // Initialisation and finalisation use the long (pa) round count
    function automatic logic op_is_pa(input logic [2:0] mode);
        return (mode == OP_INIT) || (mode == OP_FINAL);
    endfunction

    // Codes above OP_FINAL are not defined
    function automatic logic op_is_illegal(input logic [2:0] mode);
        return mode > OP_FINAL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ascon_round_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : ascon_round_cnt
//  Description : Round counter for the Ascon permutation. Latches the round
//                count n on load, steps once per active cycle and produces
//                the round-constant index (MAX_ROUNDS - n + r) and a flag
//                marking the last round. The index holds its last value
//                while the counter is not active.
//  Ports       : clk, rst        clock / synchronous active-high reset
//                load, n_rounds  latch a new round count, clear the counter
//                active          a round is being applied this cycle
//                round_idx       round-constant index for the current round
//                last            current round is the final one
//  Revision    : 1.0  initial release
// ============================================================================
module ascon_round_cnt
    import ascon_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [RC_IDX_W-1:0] n_rounds,
    input  logic                active,
    output logic [RC_IDX_W-1:0] round_idx,
    output logic                last
);

    localparam logic [RC_IDX_W-1:0] c_MAX = RC_IDX_W'(MAX_ROUNDS);

    logic [RC_IDX_W-1:0] r_n;
    logic [RC_IDX_W-1:0] r_cnt;
    logic [RC_IDX_W-1:0] r_idx_hold;
    logic [RC_IDX_W-1:0] w_idx;

    // n is at most MAX_ROUNDS, so the subtraction never goes negative
    assign w_idx = c_MAX - r_n + r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n        <= c_MAX;
            r_cnt      <= '0;
            r_idx_hold <= '0;
        end else begin
            if (load) begin
                r_n   <= n_rounds;
                r_cnt <= '0;
            end else if (active) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (active) begin
                r_idx_hold <= w_idx;
            end
        end
    end

    assign round_idx = active ? w_idx : r_idx_hold;
    assign last      = active && (r_cnt == (r_n - 1'b1));

endmodule
`default_nettype wire

// File: rtl/ascon_perm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ascon_perm_ctrl
//  Description : Sequences the Ascon permutation datapath. Accepts a
//                permutation request, runs pa or pb rounds with per-round
//                enable and round-constant index, pulses done, and
//                arbitrates state-register writes between the SPI host and
//                the running permutation (host wins while idle).
//  Ports       : clk, rst                  clock / sync active-high reset
//                req_valid/req_ready/req_mode  permutation request handshake
//                host_wr_req/host_wr_gnt   host state-write arbitration
//                round_en, round_idx       per-round datapath control
//                busy, done, err_mode      status
//                perm_cnt, round_cnt       performance counters (optional)
//  Config      : ASCON_PERF_CNT_EN adds the perm_cnt / round_cnt outputs.
//  Revision    : 1.0  initial release
// ============================================================================
module ascon_perm_ctrl
    import ascon_pkg::*;
#(
    parameter int NUM_ROUNDS_A = 12,
    parameter int NUM_ROUNDS_B = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          req_mode,
    input  logic                host_wr_req,
    output logic                host_wr_gnt,
    output logic                round_en,
    output logic [RC_IDX_W-1:0] round_idx,
    output logic                busy,
    output logic                done,
    output logic                err_mode
`ifdef ASCON_PERF_CNT_EN
    ,
    output logic [15:0]         perm_cnt,
    output logic [23:0]         round_cnt
`endif
);

    generate
        if (NUM_ROUNDS_A < 1 || NUM_ROUNDS_A > MAX_ROUNDS) begin : g_bad_rounds_a
            $error("NUM_ROUNDS_A must be in 1..12");
        end
        if (NUM_ROUNDS_B < 1 || NUM_ROUNDS_B > MAX_ROUNDS) begin : g_bad_rounds_b
            $error("NUM_ROUNDS_B must be in 1..12");
        end
    endgenerate

    localparam logic [RC_IDX_W-1:0] c_N_A = RC_IDX_W'(NUM_ROUNDS_A);
    localparam logic [RC_IDX_W-1:0] c_N_B = RC_IDX_W'(NUM_ROUNDS_B);

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic                w_accept;
    logic                w_load;
    logic                w_round_active;
    logic                w_last;
    logic [RC_IDX_W-1:0] w_n;
    logic                r_err_mode;

    // Outputs are forced low during the reset cycle so an aborted
    // permutation stops driving the datapath immediately.
    assign req_ready      = !rst && (r_state == ST_IDLE) && !host_wr_req;
    assign host_wr_gnt    = !rst && (r_state == ST_IDLE) && host_wr_req;
    assign w_round_active = !rst && (r_state == ST_ROUND);
    assign round_en       = w_round_active;
    assign busy           = !rst && ((r_state == ST_LOAD) || (r_state == ST_ROUND));
    assign done           = !rst && (r_state == ST_DONE);
    assign err_mode       = r_err_mode;

    assign w_accept = req_valid && req_ready;
    assign w_load   = w_accept && op_is_perm(req_mode);
    assign w_n      = op_is_pa(req_mode) ? c_N_A : c_N_B;

    ascon_round_cnt u_round_cnt (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .n_rounds  (w_n),
        .active    (w_round_active),
        .round_idx (round_idx),
        .last      (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_load) w_state_next = ST_LOAD;
            ST_LOAD:  w_state_next = ST_ROUND;
            ST_ROUND: if (w_last) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Sticky until reset: an illegal mode is consumed but never runs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_mode <= 1'b0;
        end else if (w_accept && op_is_illegal(req_mode)) begin
            r_err_mode <= 1'b1;
        end
    end

`ifdef ASCON_PERF_CNT_EN
    logic [15:0] r_perm_cnt;
    logic [23:0] r_round_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perm_cnt  <= '0;
            r_round_cnt <= '0;
        end else begin
            if (done) begin
                r_perm_cnt <= r_perm_cnt + 16'd1;
            end
            if (round_en) begin
                r_round_cnt <= r_round_cnt + 24'd1;
            end
        end
    end

    assign perm_cnt  = r_perm_cnt;
    assign round_cnt = r_round_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ascon_perm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ascon_perm_ctrl
//  Description : Directed self-checking bench for ascon_perm_ctrl. A second
//                instance with NUM_ROUNDS_B=8 covers the Ascon-128a pb count.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ascon_perm_ctrl;

    logic       clk;
    logic       rst;
    logic       req_valid, req_valid_b;
    logic [2:0] req_mode, req_mode_b;
    logic       host_wr_req;

    logic       req_ready, req_ready_b;
    logic       host_wr_gnt, host_wr_gnt_b;
    logic       round_en, round_en_b;
    logic [3:0] round_idx, round_idx_b;
    logic       busy, busy_b;
    logic       done, done_b;
    logic       err_mode, err_mode_b;
`ifdef ASCON_PERF_CNT_EN
    logic [15:0] perm_cnt, perm_cnt_b;
    logic [23:0] round_cnt, round_cnt_b;
`endif

    int checks;
    int failures;

    ascon_perm_ctrl #(.NUM_ROUNDS_A(12), .NUM_ROUNDS_B(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_mode    (req_mode),
        .host_wr_req (host_wr_req),
        .host_wr_gnt (host_wr_gnt),
        .round_en    (round_en),
        .round_idx   (round_idx),
        .busy        (busy),
        .done        (done),
        .err_mode    (err_mode)
`ifdef ASCON_PERF_CNT_EN
        ,
        .perm_cnt    (perm_cnt),
        .round_cnt   (round_cnt)
`endif
    );

    ascon_perm_ctrl #(.NUM_ROUNDS_A(12), .NUM_ROUNDS_B(8)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid_b),
        .req_ready   (req_ready_b),
        .req_mode    (req_mode_b),
        .host_wr_req (1'b0),
        .host_wr_gnt (host_wr_gnt_b),
        .round_en    (round_en_b),
        .round_idx   (round_idx_b),
        .busy        (busy_b),
        .done        (done_b),
        .err_mode    (err_mode_b)
`ifdef ASCON_PERF_CNT_EN
        ,
        .perm_cnt    (perm_cnt_b),
        .round_cnt   (round_cnt_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Issue one request and follow it cycle by cycle: accept in cycle 0,
    // LOAD in cycle 1, rounds in cycles 2..n+1, done in cycle n+2.
    task automatic run_perm(input bit use_b, input logic [2:0] mode, input int n, input string tag);
        logic       r_ready, r_en, r_busy, r_done;
        logic [3:0] r_idx;
        @(posedge clk); #1;
        if (use_b) begin req_valid_b = 1'b1; req_mode_b = mode; end
        else       begin req_valid   = 1'b1; req_mode   = mode; end
        @(negedge clk);
        check({tag, "_accept"}, use_b ? req_ready_b : req_ready, 1);
        for (int k = 1; k <= n + 3; k++) begin
            @(posedge clk); #1;
            // Mode changes while busy must be ignored
            if (use_b) begin req_valid_b = 1'b0; req_mode_b = 3'd7; end
            else       begin req_valid   = 1'b0; req_mode   = 3'd7; end
            @(negedge clk);
            r_ready = use_b ? req_ready_b : req_ready;
            r_en    = use_b ? round_en_b  : round_en;
            r_busy  = use_b ? busy_b      : busy;
            r_done  = use_b ? done_b      : done;
            r_idx   = use_b ? round_idx_b : round_idx;
            check($sformatf("%s_en_c%0d", tag, k + 1), r_en, (k >= 2 && k <= n + 1));
            check($sformatf("%s_busy_c%0d", tag, k + 1), r_busy, (k <= n + 1));
            check($sformatf("%s_done_c%0d", tag, k + 1), r_done, (k == n + 2));
            if (k >= 2 && k <= n + 1)
                check($sformatf("%s_idx_c%0d", tag, k + 1), r_idx, 12 - n + k - 2);
            if (k == n + 2) begin
                check({tag, "_idx_hold"}, r_idx, 11);
                check({tag, "_ready_done"}, r_ready, 0);
            end
            if (k == n + 3)
                check({tag, "_ready_idle"}, r_ready, 1);
        end
        if (use_b) req_mode_b = 3'd0;
        else       req_mode   = 3'd0;
    endtask

    initial begin
        int ndone;
        checks = 0; failures = 0;
        rst = 1'b1; req_valid = 0; req_mode = 0; req_valid_b = 0; req_mode_b = 0;
        host_wr_req = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", req_ready, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_en", round_en, 0);
        check("post_rst_done", done, 0);
        check("post_rst_err", err_mode, 0);
        check("post_rst_idx", round_idx, 0);
        check("post_rst_gnt", host_wr_gnt, 0);

        // pa and pb permutations
        run_perm(1'b0, 3'd1, 12, "init");
        run_perm(1'b0, 3'd2, 6, "ad6");
        run_perm(1'b1, 3'd2, 8, "ad8");

        // NOP: accepted, nothing runs
        @(posedge clk); #1; req_valid = 1; req_mode = 3'd0;
        @(negedge clk); check("nop_ready", req_ready, 1);
        @(posedge clk); #1; req_valid = 0;
        @(negedge clk);
        check("nop_busy", busy, 0);
        check("nop_done", done, 0);
        check("nop_err", err_mode, 0);

        // Host write wins over a simultaneous request
        @(posedge clk); #1; host_wr_req = 1; req_valid = 1; req_mode = 3'd3;
        @(negedge clk);
        check("arb_gnt", host_wr_gnt, 1);
        check("arb_ready", req_ready, 0);
        @(posedge clk); #1; host_wr_req = 0;
        @(negedge clk);
        check("arb_ready_after", req_ready, 1);
        check("arb_gnt_after", host_wr_gnt, 0);
        @(posedge clk); #1; req_valid = 0; host_wr_req = 1;
        @(negedge clk);
        check("arb_load_busy", busy, 1);
        for (int k = 2; k <= 8; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("arb_gnt_busy_c%0d", k), host_wr_gnt, 0);
            if (k == 8) check("arb_pt_done", done, 1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("arb_gnt_idle", host_wr_gnt, 1);
        @(posedge clk); #1; host_wr_req = 0; req_mode = 0;

        // Illegal mode: consumed, sticky error, nothing runs
        @(posedge clk); #1; req_valid = 1; req_mode = 3'd6;
        @(negedge clk); check("ill_ready", req_ready, 1);
        ndone = 0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1; req_valid = 0; req_mode = 0;
            @(negedge clk);
            check($sformatf("ill_busy_%0d", k), busy, 0);
            if (done) ndone++;
        end
        check("ill_no_done", ndone, 0);
        check("ill_err", err_mode, 1);
        run_perm(1'b0, 3'd4, 12, "final");
        check("err_sticky", err_mode, 1);

        // Reset in the middle of an INIT permutation (round index 5)
        @(posedge clk); #1; req_valid = 1; req_mode = 3'd1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1; req_valid = 0; req_mode = 0;
        end
        @(negedge clk);
        check("abort_pre_idx", round_idx, 5);
        @(posedge clk); #1; rst = 1;
        @(negedge clk);
        check("abort_rst_busy", busy, 0);
        check("abort_rst_en", round_en, 0);
        check("abort_rst_done", done, 0);
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_en", round_en, 0);
        check("abort_ready", req_ready, 1);
        check("abort_err_clr", err_mode, 0);
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("abort_no_done", ndone, 0);

`ifdef ASCON_PERF_CNT_EN
        check("perf_rst_perm", perm_cnt, 0);
        check("perf_rst_round", round_cnt, 0);
        run_perm(1'b0, 3'd1, 12, "p_init");
        run_perm(1'b0, 3'd2, 6, "p_ad");
        run_perm(1'b0, 3'd4, 12, "p_final");
        check("perf_perm_cnt", perm_cnt, 3);
        check("perf_round_cnt", round_cnt, 30);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
